// File: rtl/uart_pkg.sv
// UART shared definitions: state encodings, parity-type codes and line levels.
// Shared between the transmit and receive paths so both agree on frame format.
package uart_pkg;

    // State encodings
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = IDLE,
        StStart  = START,
        StData   = DATA,
        StParity = PARITY,
        StStop   = STOP
    } uart_state_e;

    // PAR_TYP codes
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Serial line levels
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Parity generator: XOR-reduces a data word and selects even or odd sense.
// Ports:
//   data    - word to protect
//   par_typ - 0 = even, 1 = odd
//   parity  - parity bit to place on the line
module parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    always_comb begin
        parity = (par_typ == PAR_EVEN) ? (^data) : ~(^data);
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter. One clk cycle is one bit period. A byte accepted while idle
// is sent as start bit, data LSB first, optional parity bit, one stop bit.
// Ports:
//   clk        - bit-rate clock
//   rst        - asynchronous reset, active low
//   P_DATA     - byte to send, sampled on acceptance
//   Data_Valid - request strobe, accepted only while not busy
//   PAR_EN     - insert parity bit (latched on acceptance)
//   PAR_TYP    - 0 = even, 1 = odd (latched on acceptance)
//   TX_OUT     - registered serial output, idles high
//   busy       - high from start bit through stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

    uart_state_e           state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [CntW-1:0]       cnt_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  par_new;

    // Parity is computed from the incoming byte and type so it can be captured
    // at acceptance; the shift register is consumed during the frame.
    parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_calc (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .parity  (par_new)
    );

    // Single-process FSM: line and busy are registered so TX_OUT is glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q   <= IDLE_LEVEL;
                    busy_q <= 1'b0;
                    if (Data_Valid) begin
                        shreg_q   <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_bit_q <= par_new;
                        tx_q      <= START_BIT;
                        busy_q    <= 1'b1;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    tx_q    <= shreg_q[0];
                    shreg_q <= shreg_q >> 1;
                    cnt_q   <= '0;
                    state_q <= StData;
                end
                StData: begin
                    if (cnt_q == CntLast) begin
                        if (par_en_q) begin
                            tx_q    <= par_bit_q;
                            state_q <= StParity;
                        end else begin
                            tx_q    <= STOP_BIT;
                            state_q <= StStop;
                        end
                    end else begin
                        tx_q    <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        cnt_q   <= cnt_q + CntW'(1);
                    end
                end
                StParity: begin
                    tx_q    <= STOP_BIT;
                    state_q <= StStop;
                end
                StStop: begin
                    tx_q    <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    tx_q    <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx: reset/idle, frames with and without parity,
// ignored requests while busy, config changes in flight, mid-frame reset.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;

    uart_tx #(
        .DATA_WIDTH(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Frame bit k is the line value after edge t0+k.
    function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic pen,
                                             input logic pbit);
        if (pen) mk_frame = {1'b0, 1'b1, pbit, d, 1'b0};
        else     mk_frame = {2'b00, 1'b1, d, 1'b0};
    endfunction

    // Called at the negedge just after acceptance edge t0. Optionally raises a
    // new request (held) after checking bit inject_k.
    task automatic check_bits(input string tag, input logic [11:0] frame, input int n,
                              input int inject_k, input logic [7:0] inject_data);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_tx%0d", tag, k), TX_OUT, frame[k]);
            chk($sformatf("%s_busy%0d", tag, k), busy, 1'b1);
            if (k == inject_k) begin
                Data_Valid = 1'b1;
                P_DATA     = inject_data;
                PAR_EN     = 1'b0;
            end
            cycle();
        end
        chk($sformatf("%s_tx_end", tag), TX_OUT, 1'b1);
        chk($sformatf("%s_busy_end", tag), busy, 1'b0);
    endtask

    // Accept a frame, then scramble inputs to prove they no longer matter.
    task automatic send(input string tag, input logic [7:0] d, input logic pen,
                        input logic ptyp, input logic exp_par);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        Data_Valid = 1'b1;
        cycle();
        Data_Valid = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pen;
        PAR_TYP    = ~ptyp;
        check_bits(tag, mk_frame(d, pen, exp_par), pen ? 11 : 10, -1, 8'h00);
        cycle();
    endtask

    initial begin
        rst        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        // Reset and idle
        #2 rst = 1'b0;
        #1;
        chk("rst_tx", TX_OUT, 1'b1);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk($sformatf("idle_tx%0d", i), TX_OUT, 1'b1);
            chk($sformatf("idle_busy%0d", i), busy, 1'b0);
        end

        // 0xA5 no parity: explicit line sequence 0,1,0,1,0,0,1,0,1,1
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b0;
        Data_Valid = 1'b1;
        cycle();
        Data_Valid = 1'b0;
        check_bits("a5_np", 12'b00_1101001010, 10, -1, 8'h00);
        cycle();

        // Parity frames: 0xA5 has four ones -> even 0, odd 1; 0x01 odd -> 0
        send("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0);
        send("a5_odd", 8'hA5, 1'b1, 1'b1, 1'b1);
        send("01_odd", 8'h01, 1'b1, 1'b1, 1'b0);

        // Back-to-back: 0xFF raised at t0+4 and held; must start after t0+11
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        Data_Valid = 1'b1;
        cycle();
        Data_Valid = 1'b0;
        check_bits("b2b_3c", mk_frame(8'h3C, 1'b0, 1'b0), 10, 3, 8'hFF);
        cycle();
        Data_Valid = 1'b0;
        check_bits("b2b_ff", mk_frame(8'hFF, 1'b0, 1'b0), 10, -1, 8'h00);
        cycle();

        // Mid-frame reset during data bit 3 (0x37: bit3 = 0)
        P_DATA     = 8'h37;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        cycle();
        Data_Valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("mid_bit3", TX_OUT, 1'b0);
        chk("mid_busy", busy, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_tx", TX_OUT, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        cycle();
        chk("post_rst_tx", TX_OUT, 1'b1);
        chk("post_rst_busy", busy, 1'b0);
        // 0xC3 has four ones -> odd parity bit 1
        send("c3_odd", 8'hC3, 1'b1, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the UART receive path.
- Accepts a parallel byte with a one-cycle valid strobe and serializes it on TX_OUT: start bit, data LSB first, optional parity bit, one stop bit.
- clk runs at the bit rate: one clk cycle equals one bit period.
- Sits between the system-side data source and the serial line; frame format matches the receiver's PAR_EN/PAR_TYP convention.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  bit-rate clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- P_DATA  input  DATA_WIDTH  byte to transmit; sampled only on acceptance.
- Data_Valid  input  1  one-cycle request strobe; accepted only when busy=0.
- PAR_EN  input  1  1 = insert parity bit; latched on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd; latched on acceptance.
- TX_OUT  output  1  serial line, idles high; registered.
- busy  output  1  high from the start bit through the stop bit.

Behaviour:
- Reset (rst=0, async): state IDLE, TX_OUT=1, busy=0, shift register and bit counter cleared.
- Reset asserted mid-frame aborts the frame immediately; the line returns high with no stop-bit completion.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - If Data_Valid=1 at edge t0, latch P_DATA, PAR_EN and PAR_TYP, and compute the parity bit. Go to START.
- START:
  - TX_OUT=0 and busy=1, visible after edge t0.
  - Next edge: go to DATA with bit counter=0.
- DATA:
  - TX_OUT = latched data bit i (LSB first), visible after edge t0+1+i.
  - Counter increments each cycle; after bit DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY:
  - TX_OUT = XOR(data) when PAR_TYP=0; ~XOR(data) when PAR_TYP=1.
  - Visible after edge t0+9 for DATA_WIDTH=8.
- STOP:
  - TX_OUT=1, busy=1, for one cycle.
  - Visible after edge t0+9 without parity, t0+10 with parity.
  - Then go to IDLE unconditionally; busy falls after edge t0+10 without parity, t0+11 with parity.
- Data_Valid while busy=1 (START through STOP) is ignored: no queuing and no error flag.
- Minimum frame period: 11 cycles without parity, 12 with parity (at least one IDLE cycle between frames).
- Config and data changes after acceptance have no effect on the frame in flight.
- Bit counter width: $clog2(DATA_WIDTH); it never wraps beyond DATA_WIDTH-1.
- TX_OUT is driven from a flop (next-state mux registered) and must be glitch-free.
- X on Data_Valid in IDLE must not corrupt state: the bench checks with 0/1 only.

Decomposition:
- Package uart_pkg:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP);
  - PAR_EVEN=0, PAR_ODD=1;
  - START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
  - Shared with the receive path.
- One sub-module, parity_calc: combinational XOR reduce of the latched byte plus PAR_TYP select.
- The serializer shift register, counter and FSM stay in uart_tx.

Test Plan:
- Reset then idle 20 cycles -> TX_OUT=1, busy=0 throughout.
- P_DATA=0xA5, PAR_EN=0, Data_Valid pulse -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 over 10 cycles; busy high exactly 10 cycles.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 then 1 -> parity bit 0 (even) then 1 (odd); 11-bit frames.
- P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> parity bit 0.
- Back-to-back: Data_Valid=0x3C at t0 and 0xFF at t0+4 (ignored), then 0xFF held until accepted -> only 0x3C sent first; 0xFF start bit after edge t0+11, frame correct.
- rst pulsed low during DATA bit 3 -> TX_OUT=1 and busy=0 immediately; the next accepted frame is fully correct.
